switch_block_param: RTL
=======================

SWITCH_BLOCK_PARAM -- requirements
Module: switch_block_param

Interface
REQ-001 The block SHALL have parameter CHANNEL_ONEWAY_WIDTH, default 4, meaning tracks per direction per side (W, legal range 2..16).
REQ-002 The block SHALL have port scan_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports scan_en, input, 1 bit (shift enable); scan_in, input, 1 bit (serial config in); and scan_out, output, 1 bit (serial config out).
REQ-005 The block SHALL have ports left_in, right_in, top_in and bottom_in, input, W bits each: incoming tracks.
REQ-006 The block SHALL have ports left_out, right_out, top_out and bottom_out, output, W bits each: outgoing tracks.
REQ-007 The block SHALL have ports left_clb_in and right_clb_in, input, 1 bit each: CLB outputs injected onto the channel.
REQ-008 The block SHALL have ports cfg_valid, cfg_err and cfg_busy, output, 1 bit each: config status.

Function
REQ-009 Config SHALL be CFG_BITS = 8W bits, ordered {bottom, top, right, left}, 2W bits per side; track i of a side SHALL use bits [2i+1:2i] of that side.
REQ-010 Side order SHALL be clockwise left->top->right->bottom; the side-X output track i select SHALL be: 0 = opposite side track i; 1 = clockwise neighbour side track (i+1) mod W; 2 = counter-clockwise neighbour side track W-1-i; 3 = clb_in of the same side for track W-1 of left/right, otherwise constant 0.
REQ-011 Track outputs SHALL be combinational from the inputs and the active config register, with zero-cycle latency.
REQ-012 Shadow register (CHAIN_LEN bits) SHALL shift {scan_in, shadow[CHAIN_LEN-1:1]} on each cycle with scan_en=1 in IDLE or SHIFT.
REQ-013 scan_out SHALL equal shadow[0].
REQ-014 Shifting SHALL never alter the active config.
REQ-015 The FSM SHALL have states IDLE, SHIFT, CHECK and COMMIT. Transitions: IDLE->SHIFT when scan_en=1; SHIFT->CHECK on the first cycle with scan_en=0; CHECK->COMMIT if the check passes; CHECK->IDLE with cfg_err=1 otherwise; COMMIT->IDLE.
REQ-016 A bit counter SHALL count shifts and saturate at CHAIN_LEN+1. It SHALL clear when IDLE->SHIFT, and that entry cycle SHALL count as shift 1.
REQ-017 The check SHALL pass only when count == CHAIN_LEN exactly, plus parity when enabled (REQ-024).
REQ-018 COMMIT SHALL copy shadow[CFG_BITS-1:0] to active and set cfg_valid=1, which stays 1 until reset; new routing SHALL take effect the cycle after COMMIT.
REQ-019 cfg_err SHALL clear on IDLE->SHIFT and remain set otherwise.
REQ-020 cfg_busy SHALL be 1 in SHIFT, CHECK and COMMIT.
REQ-021 scan_en=1 in CHECK or COMMIT SHALL be a protocol violation: no shift occurs, cfg_err is set, no commit happens, and the next state is IDLE.
REQ-022 While cfg_valid=0, all *_out tracks SHALL be 0 regardless of inputs.

Reset
REQ-023 On rst_n=0, state SHALL go to IDLE and counter, shadow, active, cfg_valid, cfg_err, cfg_busy, scan_out and all track outputs SHALL go to 0. Reset mid-shift SHALL discard the partial load, and the previous active config is lost.

Configuration
REQ-024 Macro SB_CFG_PARITY_EN defined: CHAIN_LEN = CFG_BITS+1, the last bit shifted (shadow MSB) is an even-parity bit, and the check additionally requires the XOR of all CHAIN_LEN bits to be 0.
REQ-025 Macro SB_CFG_PARITY_EN undefined: CHAIN_LEN = CFG_BITS and no parity logic exists.

Structure
REQ-026 Shared package sb_pkg SHALL hold the select encodings (SEL_STRAIGHT, SEL_CW, SEL_CCW, SEL_CLB), the FSM state enum and the CFG_BITS/CHAIN_LEN constant functions.
REQ-027 Sub-module sb_cfg_ctrl SHALL contain the shadow, counter, FSM and active register.
REQ-028 The routing muxes SHALL be generated in the top module.

Verification (W=4, CFG_BITS=32, parity off unless stated)
REQ-029 Reset release with all inputs 1 -> all outputs 0, cfg_valid=0, scan_out=0.
REQ-030 Shift 32 bits all 0, drop scan_en -> cfg_busy=1 for 3 cycles, then cfg_valid=1; left_out == right_in, top_out == bottom_in.
REQ-031 Shift 31 bits, drop scan_en -> cfg_err=1, cfg_valid unchanged, routing unchanged; 33 bits -> same result.
REQ-032 Left config track 3 = 3, left_clb_in toggling -> left_out[3] follows; top config = all 3 -> top_out = 0.
REQ-033 Assert scan_en during CHECK -> cfg_err=1, no commit; then a correct 32-bit load -> cfg_err clears on its first shift and the load commits.
REQ-034 Parity on: 33 bits with correct parity -> commit; single bit flipped -> cfg_err=1; rst_n pulsed mid-shift -> all state 0.

Source files
------------

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the parameterised switch block.
//
// Contents:
//   SEL_*          2-bit per-track route select encodings
//   SIDE_*         side index as laid out in the config word (left at the LSBs)
//   sb_state_t     configuration FSM states
//   cfg_bits()     active config width for a given track count
//   chain_len()    scan chain length (config plus optional parity bit)
//   cnt_width()    width of the shift counter (holds 0..chain_len+1)
//   *_side()       side-adjacency helpers used to build the routing muxes
//
// Optional feature macro: SB_CFG_PARITY_EN (adds one even-parity bit to the
// scan chain and makes the load check require correct parity).
// -----------------------------------------------------------------------------
package sb_pkg;

    localparam logic [1:0] SEL_STRAIGHT = 2'd0;
    localparam logic [1:0] SEL_CW       = 2'd1;
    localparam logic [1:0] SEL_CCW      = 2'd2;
    localparam logic [1:0] SEL_CLB      = 2'd3;

    // Side indices follow the config word layout {bottom, top, right, left},
    // not the clockwise ring order, so a side's field sits at index*2W.
    localparam int SIDE_LEFT   = 0;
    localparam int SIDE_RIGHT  = 1;
    localparam int SIDE_TOP    = 2;
    localparam int SIDE_BOTTOM = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } sb_state_t;

    function automatic int cfg_bits(input int w);
        return 8 * w;
    endfunction

    function automatic int chain_len(input int w);
`ifdef SB_CFG_PARITY_EN
        return cfg_bits(w) + 1;
`else
        return cfg_bits(w);
`endif
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(chain_len(w) + 2);
    endfunction

    function automatic int opposite_side(input int s);
        case (s)
            SIDE_LEFT:  return SIDE_RIGHT;
            SIDE_RIGHT: return SIDE_LEFT;
            SIDE_TOP:   return SIDE_BOTTOM;
            default:    return SIDE_TOP;
        endcase
    endfunction

    // Clockwise ring is left -> top -> right -> bottom -> left.
    function automatic int cw_side(input int s);
        case (s)
            SIDE_LEFT:  return SIDE_TOP;
            SIDE_TOP:   return SIDE_RIGHT;
            SIDE_RIGHT: return SIDE_BOTTOM;
            default:    return SIDE_LEFT;
        endcase
    endfunction

    function automatic int ccw_side(input int s);
        case (s)
            SIDE_LEFT:  return SIDE_BOTTOM;
            SIDE_TOP:   return SIDE_LEFT;
            SIDE_RIGHT: return SIDE_TOP;
            default:    return SIDE_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/sb_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// sb_cfg_ctrl
// Scan-loaded configuration controller for the switch block. Holds the scan
// shadow register, the shift counter, the load FSM and the active config.
// A load is only accepted when exactly chain_len bits were shifted (and, with
// SB_CFG_PARITY_EN defined, when the chain has even parity).
//
// Ports:
//   scan_clk   in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   scan_en    in   shift enable
//   scan_in    in   serial config input (enters at shadow MSB)
//   scan_out   out  serial config output (shadow LSB)
//   active     out  committed config word, cfg_bits(W) wide
//   cfg_valid  out  a config has been committed since reset
//   cfg_err    out  last load was rejected or violated the protocol
//   cfg_busy   out  load in progress (SHIFT, CHECK or COMMIT)
//
// Optional feature macro: SB_CFG_PARITY_EN.
// -----------------------------------------------------------------------------
module sb_cfg_ctrl
    import sb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                   scan_clk,
    input  logic                   rst_n,
    input  logic                   scan_en,
    input  logic                   scan_in,
    output logic                   scan_out,
    output logic [cfg_bits(W)-1:0] active,
    output logic                   cfg_valid,
    output logic                   cfg_err,
    output logic                   cfg_busy
);

    localparam int CFG_BITS  = cfg_bits(W);
    localparam int CHAIN_LEN = chain_len(W);
    localparam int CNT_W     = cnt_width(W);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sb_state_t              state;
    sb_state_t              next_state;
    logic [CHAIN_LEN-1:0]   shadow;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   do_shift;
    logic                   start_load;
    logic                   set_err;
    logic                   do_commit;
    logic                   check_ok;

    // The counter saturates one past the chain length, so any overlong load
    // stays distinguishable from an exact one no matter how long it runs.
`ifdef SB_CFG_PARITY_EN
    assign check_ok = (bit_cnt == CNT_FULL) && !(^shadow);
`else
    assign check_ok = (bit_cnt == CNT_FULL);
`endif

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Shifting is only legal in IDLE and SHIFT; scan_en seen in CHECK or
    // COMMIT aborts the load with an error instead of shifting.
    always_comb begin
        next_state = state;
        do_shift   = 1'b0;
        start_load = 1'b0;
        set_err    = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (scan_en) begin
                    next_state = SHIFT;
                    do_shift   = 1'b1;
                    start_load = 1'b1;
                end
            end
            SHIFT: begin
                if (scan_en) begin
                    do_shift = 1'b1;
                end else begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (scan_en || !check_ok) begin
                    set_err    = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                next_state = IDLE;
                if (scan_en) begin
                    set_err = 1'b1;
                end else begin
                    do_commit = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The entry shift from IDLE loads the counter with 1 directly so that it
    // counts as the first shift of the new load.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            bit_cnt   <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (do_shift) begin
                shadow <= {scan_in, shadow[CHAIN_LEN-1:1]};
            end
            if (start_load) begin
                bit_cnt <= CNT_ONE;
            end else if (do_shift && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (start_load) begin
                cfg_err <= 1'b0;
            end else if (set_err) begin
                cfg_err <= 1'b1;
            end
            if (do_commit) begin
                active    <= shadow[CFG_BITS-1:0];
                cfg_valid <= 1'b1;
            end
        end
    end

    assign scan_out = shadow[0];
    assign cfg_busy = (state != IDLE);

endmodule

// File: rtl/switch_block_param.sv
// -----------------------------------------------------------------------------
// switch_block_param
// Parameterised FPGA-style switch block. Each outgoing track picks, via a
// 2-bit scan-loaded select, the opposite side's same track, a rotated track
// of the clockwise neighbour, a mirrored track of the counter-clockwise
// neighbour, or (top track of left/right only) the adjacent CLB output.
// Routing is purely combinational from the committed config; all outputs are
// held at 0 until a config has been committed.
//
// Parameter:
//   CHANNEL_ONEWAY_WIDTH  tracks per direction per side (2..16)
// Ports:
//   scan_clk, rst_n                   clock, async active-low reset
//   scan_en, scan_in, scan_out        serial config interface
//   left/right/top/bottom_in  [W]     incoming tracks
//   left/right/top/bottom_out [W]     outgoing tracks
//   left_clb_in, right_clb_in         CLB outputs injected on track W-1
//   cfg_valid, cfg_err, cfg_busy      config status
//
// Optional feature macro: SB_CFG_PARITY_EN (even-parity bit on the chain).
// -----------------------------------------------------------------------------
module switch_block_param
    import sb_pkg::*;
#(
    parameter int CHANNEL_ONEWAY_WIDTH = 4
) (
    input  logic                            scan_clk,
    input  logic                            rst_n,
    input  logic                            scan_en,
    input  logic                            scan_in,
    output logic                            scan_out,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] left_in,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] right_in,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] top_in,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] bottom_in,
    output logic [CHANNEL_ONEWAY_WIDTH-1:0] left_out,
    output logic [CHANNEL_ONEWAY_WIDTH-1:0] right_out,
    output logic [CHANNEL_ONEWAY_WIDTH-1:0] top_out,
    output logic [CHANNEL_ONEWAY_WIDTH-1:0] bottom_out,
    input  logic                            left_clb_in,
    input  logic                            right_clb_in,
    output logic                            cfg_valid,
    output logic                            cfg_err,
    output logic                            cfg_busy
);

    localparam int W        = CHANNEL_ONEWAY_WIDTH;
    localparam int CFG_BITS = cfg_bits(W);

    logic [CFG_BITS-1:0]  active;
    logic [3:0][W-1:0]    side_in;
    logic [3:0][W-1:0]    side_out;
    logic [3:0]           side_clb;

    sb_cfg_ctrl #(
        .W (W)
    ) u_cfg_ctrl (
        .scan_clk  (scan_clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .active    (active),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err),
        .cfg_busy  (cfg_busy)
    );

    assign side_in[SIDE_LEFT]   = left_in;
    assign side_in[SIDE_RIGHT]  = right_in;
    assign side_in[SIDE_TOP]    = top_in;
    assign side_in[SIDE_BOTTOM] = bottom_in;

    // Top and bottom have no CLB neighbour; their SEL_CLB setting drives 0.
    assign side_clb = {1'b0, 1'b0, right_clb_in, left_clb_in};

    assign left_out   = side_out[SIDE_LEFT];
    assign right_out  = side_out[SIDE_RIGHT];
    assign top_out    = side_out[SIDE_TOP];
    assign bottom_out = side_out[SIDE_BOTTOM];

    // One 4:1 mux per outgoing track. Source sides and track indices are
    // resolved at elaboration, so each mux sees only four fixed wires.
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < W; i++) begin : g_trk
            localparam int OPP     = opposite_side(s);
            localparam int CW      = cw_side(s);
            localparam int CCW     = ccw_side(s);
            localparam int CW_TRK  = (i + 1) % W;
            localparam int CCW_TRK = W - 1 - i;
            localparam bit HAS_CLB = (i == W - 1) &&
                                     ((s == SIDE_LEFT) || (s == SIDE_RIGHT));

            logic [1:0] sel;
            logic       trk;

            assign sel = active[s*2*W + 2*i +: 2];

            always_comb begin
                trk = 1'b0;
                if (cfg_valid) begin
                    case (sel)
                        SEL_STRAIGHT: trk = side_in[OPP][i];
                        SEL_CW:       trk = side_in[CW][CW_TRK];
                        SEL_CCW:      trk = side_in[CCW][CCW_TRK];
                        SEL_CLB:      trk = HAS_CLB ? side_clb[s] : 1'b0;
                        default:      trk = 1'b0;
                    endcase
                end
            end

            assign side_out[s][i] = trk;
        end
    end

endmodule
